arrow_spawner: RTL and testbench

Scheduler that sits directly upstream of the arrow sprite stage and drives its valid_in/speed_in/direction_in/inversed_in inputs. It launches one arrow at a time, with pseudo-random direction and random inter-arrow gaps measured in frames. Each arrow is retired on the arrow stage's hit_player pulse or on a flight timeout. A saturating speed level rises as spawns accumulate.

---
 rtl/arrow_spawner_if.sv | 26 ++
 rtl/arrow_spawner.sv | 168 ++++++++++++++++
 tb/tb_arrow_spawner.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arrow_spawner_if.sv
// Signal bundle between the video/game side and the arrow spawner.
// The spawner connects through the slave modport; the game side uses master.
interface arrow_spawner_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        enable_in;
  logic        hit_player_in;
  logic        arrow_valid_out;
  logic [1:0]  direction_out;
  logic [2:0]  speed_out;
  logic        inversed_out;
  logic [7:0]  spawn_count_out;
  logic        busy_out;

  modport master (
    output hcount_in, vcount_in, enable_in, hit_player_in,
    input  arrow_valid_out, direction_out, speed_out, inversed_out,
           spawn_count_out, busy_out
  );

  modport slave (
    input  hcount_in, vcount_in, enable_in, hit_player_in,
    output arrow_valid_out, direction_out, speed_out, inversed_out,
           spawn_count_out, busy_out
  );
endinterface

// File: rtl/arrow_spawner.sv
// One-at-a-time arrow launcher with LFSR-driven direction/gaps and a speed ramp.
// Define ARROW_SPAWNER_INVERSE_EN to randomise inversed_out once speed reaches 4.
module arrow_spawner #(
  parameter int          GAP_BASE       = 30,
  parameter int          GAP_RAND_BITS  = 4,
  parameter int          FLIGHT_TIMEOUT = 200,
  parameter int          SPEEDUP_EVERY  = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  arrow_spawner_if.slave bus
);
  localparam int GAP_W = $clog2(GAP_BASE + (1 << GAP_RAND_BITS)) + 1;
  localparam int FLT_W = $clog2(FLIGHT_TIMEOUT + 1);
  localparam int SPD_W = $clog2(SPEEDUP_EVERY + 1);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_LAUNCH, S_FLIGHT, S_RETIRE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_target_q, gap_target_d;
  logic [FLT_W-1:0] flight_cnt_q, flight_cnt_d;
  logic [SPD_W-1:0] speedup_q, speedup_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [1:0]       dir_q, dir_d;
  logic [2:0]       speed_q, speed_d;
  logic [7:0]       spawn_q, spawn_d;
  logic             frame_tick;
  logic [GAP_W-1:0] new_target;

`ifdef ARROW_SPAWNER_INVERSE_EN
  logic inv_q, inv_d;
  assign bus.inversed_out = inv_q;
`else
  assign bus.inversed_out = 1'b0;
`endif

  assign frame_tick = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  assign new_target = GAP_W'(GAP_BASE) + GAP_W'(lfsr_q[GAP_RAND_BITS+1:2]);

  always_comb begin
    state_d      = state_q;
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    gap_cnt_d    = gap_cnt_q;
    gap_target_d = gap_target_q;
    flight_cnt_d = flight_cnt_q;
    speedup_d    = speedup_q;
    valid_d      = valid_q;
    dir_d        = dir_q;
    speed_d      = speed_q;
    spawn_d      = spawn_q;
`ifdef ARROW_SPAWNER_INVERSE_EN
    inv_d        = inv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.enable_in) begin
          state_d      = S_GAP;
          gap_cnt_d    = '0;
          gap_target_d = new_target;
        end
      end
      S_GAP: begin
        if (!bus.enable_in) begin
          state_d = S_IDLE;
        end else if (frame_tick) begin
          // Launch side effects are registered here so valid rises the cycle after the expiry tick.
          if ((gap_cnt_q + GAP_W'(1)) == gap_target_q) begin
            state_d = S_LAUNCH;
            dir_d   = lfsr_q[1:0];
            valid_d = 1'b1;
            spawn_d = spawn_q + 8'd1;
`ifdef ARROW_SPAWNER_INVERSE_EN
            inv_d   = (speed_q >= 3'd4) ? lfsr_q[7] : 1'b0;
`endif
            if ((speedup_q + SPD_W'(1)) == SPD_W'(SPEEDUP_EVERY)) begin
              speedup_d = '0;
              speed_d   = (speed_q == 3'd7) ? 3'd7 : speed_q + 3'd1;
            end else begin
              speedup_d = speedup_q + SPD_W'(1);
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      S_LAUNCH: begin
        if (!bus.enable_in) begin
          state_d = S_RETIRE;
          valid_d = 1'b0;
        end else begin
          state_d      = S_FLIGHT;
          flight_cnt_d = '0;
        end
      end
      S_FLIGHT: begin
        if (!bus.enable_in || bus.hit_player_in) begin
          state_d = S_RETIRE;
          valid_d = 1'b0;
        end else if (frame_tick) begin
          if ((flight_cnt_q + FLT_W'(1)) == FLT_W'(FLIGHT_TIMEOUT)) begin
            state_d = S_RETIRE;
            valid_d = 1'b0;
          end else begin
            flight_cnt_d = flight_cnt_q + FLT_W'(1);
          end
        end
      end
      S_RETIRE: begin
        // Holding until a frame tick guarantees the arrow stage sees valid low for a while.
        if (frame_tick) begin
          if (bus.enable_in) begin
            state_d      = S_GAP;
            gap_cnt_d    = '0;
            gap_target_d = new_target;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LAUNCH) || (state_d == S_FLIGHT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      gap_cnt_q    <= '0;
      gap_target_q <= '0;
      flight_cnt_q <= '0;
      speedup_q    <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      dir_q        <= 2'b00;
      speed_q      <= 3'd1;
      spawn_q      <= 8'd0;
`ifdef ARROW_SPAWNER_INVERSE_EN
      inv_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_target_q <= gap_target_d;
      flight_cnt_q <= flight_cnt_d;
      speedup_q    <= speedup_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      dir_q        <= dir_d;
      speed_q      <= speed_d;
      spawn_q      <= spawn_d;
`ifdef ARROW_SPAWNER_INVERSE_EN
      inv_q        <= inv_d;
`endif
    end
  end

  assign bus.arrow_valid_out = valid_q;
  assign bus.direction_out   = dir_q;
  assign bus.speed_out       = speed_q;
  assign bus.spawn_count_out = spawn_q;
  assign bus.busy_out        = busy_q;
endmodule

// File: tb/tb_arrow_spawner.sv
// Bench for arrow_spawner: frame-level reference model, ramp table and corner-case sequences.
// Frames are shortened to 4 clocks so long gap/flight spans stay cheap to simulate.
module tb_arrow_spawner;
  localparam int GAP_BASE       = 30;
  localparam int FLIGHT_TIMEOUT = 200;
  localparam int SPEEDUP_EVERY  = 8;
  localparam int FP             = 4;
  localparam int P_IDLE = 0, P_GAP = 1, P_LAUNCH = 2, P_FLIGHT = 3, P_RETIRE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  arrow_spawner_if intf();
  arrow_spawner dut (.clk(clk), .rst(rst_n), .bus(intf));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ph       = 0;

  int          m_phase, m_left, m_total;
  logic [15:0] m_lfsr;
  logic        m_valid, m_inv, m_busy;
  logic [1:0]  m_dir;
  logic [2:0]  m_speed;
  logic [7:0]  m_spawn;
  logic [15:0] last_dut, last_mod;

  typedef struct {
    int         launches;
    logic [2:0] speed;
    logic [7:0] spawn;
  } ramp_t;
  ramp_t tbl[8];

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int v, fb;
    v  = int'(x);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 16'hFFFF);
  endfunction

  function automatic int gap_frames(input logic [15:0] x);
    return GAP_BASE + ((int'(x) >> 2) & 15);
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_left = 0; m_total = 0; m_lfsr = 16'hACE1;
    m_valid = 1'b0; m_dir = 2'd0; m_speed = 3'd1; m_inv = 1'b0;
    m_spawn = 8'd0; m_busy = 1'b0;
  endtask

  // Frame-level model: counts remaining frames down, speed derived from total launches.
  task automatic model_update(input bit en, input bit hit, input bit tick);
    logic [15:0] l;
    int          lvl;
    l = m_lfsr;
    case (m_phase)
      P_IDLE: if (en) begin m_phase = P_GAP; m_left = gap_frames(l); end
      P_GAP: begin
        if (!en) m_phase = P_IDLE;
        else if (tick) begin
          m_left--;
          if (m_left == 0) begin
`ifdef ARROW_SPAWNER_INVERSE_EN
            m_inv = (m_speed >= 3'd4) ? l[7] : 1'b0;
`endif
            m_total++;
            lvl     = 1 + m_total / SPEEDUP_EVERY;
            m_speed = 3'((lvl > 7) ? 7 : lvl);
            m_spawn = 8'(m_total % 256);
            m_dir   = 2'(int'(l) & 3);
            m_valid = 1'b1;
            m_phase = P_LAUNCH;
          end
        end
      end
      P_LAUNCH: begin
        if (!en) begin m_phase = P_RETIRE; m_valid = 1'b0; end
        else begin m_phase = P_FLIGHT; m_left = FLIGHT_TIMEOUT; end
      end
      P_FLIGHT: begin
        if (!en || hit) begin m_phase = P_RETIRE; m_valid = 1'b0; end
        else if (tick) begin
          m_left--;
          if (m_left == 0) begin m_phase = P_RETIRE; m_valid = 1'b0; end
        end
      end
      default: begin
        if (tick) begin
          if (en) begin m_phase = P_GAP; m_left = gap_frames(l); end
          else m_phase = P_IDLE;
        end
      end
    endcase
    m_busy = (m_phase == P_LAUNCH) || (m_phase == P_FLIGHT);
    m_lfsr = lfsr_step(l);
  endtask

  function automatic logic [15:0] dut_vec();
    return {intf.arrow_valid_out, intf.direction_out, intf.speed_out, intf.inversed_out,
            intf.spawn_count_out, intf.busy_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One comparison against the model whenever either side's outputs change.
  task automatic compare_txn();
    logic [15:0] dv, mv;
    dv = dut_vec();
    mv = {m_valid, m_dir, m_speed, m_inv, m_spawn, m_busy};
    if (dv !== last_dut || mv !== last_mod) begin
      checks++;
      if (dv !== mv) begin
        failures++;
        $display("FAIL txn t=%0t: dut v=%b d=%0d s=%0d i=%b n=%0d b=%b, model v=%b d=%0d s=%0d i=%b n=%0d b=%b",
                 $time, dv[15], dv[14:13], dv[12:10], dv[9], dv[8:1], dv[0],
                 mv[15], mv[14:13], mv[12:10], mv[9], mv[8:1], mv[0]);
      end else begin
        $display("txn t=%0t valid=%b dir=%0d speed=%0d inv=%b spawn=%0d busy=%b",
                 $time, dv[15], dv[14:13], dv[12:10], dv[9], dv[8:1], dv[0]);
      end
      last_dut = dv;
      last_mod = mv;
    end
  endtask

  task automatic step();
    bit en, hit, tick;
    intf.hcount_in = (ph == 2) ? 11'd0 : 11'(ph);
    intf.vcount_in = (ph == 2) ? 10'd5 : 10'd0;
    en   = intf.enable_in;
    hit  = intf.hit_player_in;
    tick = (ph == 0);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update(en, hit, tick);
    ph = (ph + 1) % FP;
    @(negedge clk);
    compare_txn();
  endtask

  task automatic wait_valid(input logic level, input int max_cycles, input string name,
                            output int ticks, output bit ok);
    ticks = 0;
    ok    = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (ph == 0) ticks++;
      step();
      if (intf.arrow_valid_out == level) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: valid never reached %b within %0d cycles", name, level, max_cycles);
    end
  endtask

  task automatic retire_by_hit();
    step();
    intf.hit_player_in = 1'b1;
    step();
    intf.hit_player_in = 1'b0;
  endtask

  task automatic run_to(input int n);
    int t;
    bit ok;
    for (int k = 0; k < 600 && m_total < n; k++) begin
      wait_valid(1'b1, 400, "ramp_launch", t, ok);
      if (!ok) break;
      if (m_total < n) retire_by_hit();
    end
  endtask

  task automatic disable_test();
    int t, launched;
    bit ok;
    wait_valid(1'b1, 400, "dis_launch", t, ok);
    step(); step();
    intf.enable_in = 1'b0;
    step();
    check("dis_drop", intf.arrow_valid_out, 0);
    launched = 0;
    repeat (400) begin
      step();
      if (intf.arrow_valid_out) launched++;
    end
    check("dis_quiet", launched, 0);
    check("dis_busy", intf.busy_out, 0);
    check("dis_spawn", intf.spawn_count_out, 17);
    check("dis_speed", intf.speed_out, 3);
    intf.enable_in = 1'b1;
    wait_valid(1'b1, 400, "reen_launch", t, ok);
    check("reen_spawn", intf.spawn_count_out, 18);
    check("reen_speed", intf.speed_out, 3);
    retire_by_hit();
  endtask

  initial begin
    int t;
    bit ok;
    tbl[0] = '{8, 3'd2, 8'd8};     tbl[1] = '{16, 3'd3, 8'd16};
    tbl[2] = '{48, 3'd7, 8'd48};   tbl[3] = '{56, 3'd7, 8'd56};
    tbl[4] = '{64, 3'd7, 8'd64};   tbl[5] = '{255, 3'd7, 8'd255};
    tbl[6] = '{256, 3'd7, 8'd0};   tbl[7] = '{257, 3'd7, 8'd1};
    intf.enable_in = 1'b0; intf.hit_player_in = 1'b0;
    intf.hcount_in = 11'd0; intf.vcount_in = 10'd0;
    last_dut = 'x; last_mod = 'x;
    model_reset();

    repeat (3) step();
    check("reset_vec", dut_vec(), {1'b0, 2'd0, 3'd1, 1'b0, 8'd0, 1'b0});
    rst_n = 1'b1;

    intf.enable_in = 1'b1;
    step();
    wait_valid(1'b1, 400, "first_launch", t, ok);
    check("first_gap_min", t >= 30, 1);
    check("first_gap_max", t <= 45, 1);
    check("first_spawn", intf.spawn_count_out, 1);
    check("first_speed", intf.speed_out, 1);

    step(); step();
    intf.hit_player_in = 1'b1;
    step();
    intf.hit_player_in = 1'b0;
    check("hit_drop", intf.arrow_valid_out, 0);
    check("hit_busy", intf.busy_out, 0);
    wait_valid(1'b1, 400, "relaunch", t, ok);
    check("relaunch_spawn", intf.spawn_count_out, 2);

    wait_valid(1'b0, 1200, "timeout", t, ok);
    check("timeout_frames", t, FLIGHT_TIMEOUT);

    for (int i = 0; i < 8; i++) begin
      run_to(tbl[i].launches);
      check($sformatf("ramp%0d_speed", tbl[i].launches), intf.speed_out, tbl[i].speed);
      check($sformatf("ramp%0d_spawn", tbl[i].launches), intf.spawn_count_out, tbl[i].spawn);
      retire_by_hit();
      if (i == 1) disable_test();
    end

    for (int i = 0; i < 3000; i++) begin
      intf.hit_player_in = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) intf.enable_in = ~intf.enable_in;
      step();
    end
    intf.hit_player_in = 1'b0;
    intf.enable_in     = 1'b1;

    wait_valid(1'b1, 1200, "pre_reset_launch", t, ok);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", intf.arrow_valid_out, 0);
    check("areset_speed", intf.speed_out, 1);
    check("areset_spawn", intf.spawn_count_out, 0);
    check("areset_busy", intf.busy_out, 0);
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    wait_valid(1'b1, 400, "post_reset_launch", t, ok);
    check("post_reset_inv", intf.inversed_out, 0);
    check("post_reset_spawn", intf.spawn_count_out, 1);
    check("post_reset_speed", intf.speed_out, 1);
    retire_by_hit();
    repeat (200) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
